// File: rtl/chunked_seq_adder.sv
// chunked_seq_adder: multi-cycle adder/subtractor that processes CHUNK bits per clock,
// keeping the inter-chunk carry in a register. Operands enter through a valid/ready
// handshake, and results leave through a second valid/ready handshake.
// Optional build macro ADDER_SAT_EN: unsigned saturation of sum on completion
// (add with carry -> all ones, sub with borrow -> zero). carry_out/overflow stay raw.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake
//   a, b, cin, sub       operands, carry-in (add only), subtract select
//   out_valid, out_ready result handshake
//   sum, carry_out       result and final carry (sub: 1 = no borrow)
//   overflow             two's-complement signed overflow
module chunked_seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic              carry_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
`ifdef ADDER_SAT_EN
    logic              sub_reg;
`endif

    logic              xfer_c;
    logic              last_c;
    int unsigned       base_c;
    logic [CHUNK-1:0]  a_k_c;
    logic [CHUNK-1:0]  b_k_c;
    logic [CHUNK:0]    chunk_c;
    logic [WIDTH-1:0]  sum_raw_c;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        xfer_c    = 1'b0;
        last_c    = (cnt == CW'(NCH - 1));
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    xfer_c    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One chunk of the add; shifts select the chunk so CHUNK == WIDTH needs no special case
    always_comb begin
        base_c    = 32'(cnt) * CHUNK;
        a_k_c     = CHUNK'(a_reg >> base_c);
        b_k_c     = CHUNK'(b_reg >> base_c);
        chunk_c   = {1'b0, a_k_c} + {1'b0, b_k_c} + {{CHUNK{1'b0}}, carry_reg};
        sum_raw_c = (sum & ~(CMASK << base_c)) | (WIDTH'(chunk_c[CHUNK-1:0]) << base_c);
    end

    // State register, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
`ifdef ADDER_SAT_EN
            sub_reg   <= 1'b0;
`endif
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            if (xfer_c) begin
                a_reg     <= a;
                b_reg     <= sub ? ~b : b;
                carry_reg <= sub ? 1'b1 : cin;
`ifdef ADDER_SAT_EN
                sub_reg   <= sub;
`endif
                cnt       <= '0;
            end else if (state == RUN) begin
                sum       <= sum_raw_c;
                carry_reg <= chunk_c[CHUNK];
                cnt       <= cnt + CW'(1);
                if (last_c) begin
                    carry_out <= chunk_c[CHUNK];
                    // Operand signs agree but result sign differs
                    overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (sum_raw_c[WIDTH-1] != a_reg[WIDTH-1]);
`ifdef ADDER_SAT_EN
                    if (!sub_reg && chunk_c[CHUNK]) begin
                        sum <= '1;
                    end else if (sub_reg && !chunk_c[CHUNK]) begin
                        sum <= '0;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed self-checking bench for chunked_seq_adder.
// Instance 0: WIDTH=16/CHUNK=4, instance 1: CHUNK=16, instance 2: CHUNK=1.
// Operand buses are shared; each instance has its own handshake signals.
module tb_chunked_seq_adder;

`ifdef ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        iv   [3];
    logic        irdy [3];
    logic        ovl  [3];
    logic        ordy [3];
    logic [15:0] sm   [3];
    logic        co   [3];
    logic        ovf  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ovl[0]), .out_ready(ordy[0]),
        .sum(sm[0]), .carry_out(co[0]), .overflow(ovf[0])
    );

    chunked_seq_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ovl[1]), .out_ready(ordy[1]),
        .sum(sm[1]), .carry_out(co[1]), .overflow(ovf[1])
    );

    chunked_seq_adder #(.WIDTH(16), .CHUNK(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ovl[2]), .out_ready(ordy[2]),
        .sum(sm[2]), .carry_out(co[2]), .overflow(ovf[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation on instance d with result checks, optional
    // backpressure (hold cycles) and optional input churn during RUN.
    task automatic op(input int d, input string tag,
                      input logic [15:0] ta, input logic [15:0] tb_v,
                      input logic tcin, input logic tsub,
                      input int hold, input bit meddle, input int elat,
                      input logic [15:0] esum, input logic eco, input logic eov);
        int          n;
        int          lat;
        logic [15:0] rs;
        logic        rc;
        n = 0;
        while (!irdy[d] && n < 50) begin
            step();
            n++;
        end
        check({tag, "_rdy"}, 32'(irdy[d]), 32'd1);
        a = ta; b = tb_v; cin = tcin; sub = tsub;
        iv[d] = 1'b1;
        step();
        if (meddle) begin
            a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub;
        end else begin
            iv[d] = 1'b0;
        end
        lat = 0;
        while (!ovl[d] && lat < 40) begin
            if (meddle) check({tag, "_run_rdy"}, 32'(irdy[d]), 32'd0);
            step();
            lat++;
        end
        iv[d] = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_sum"}, 32'(sm[d]), 32'(esum));
        check({tag, "_co"}, 32'(co[d]), 32'(eco));
        check({tag, "_ov"}, 32'(ovf[d]), 32'(eov));
        rs = sm[d];
        rc = co[d];
        repeat (hold) begin
            step();
            check({tag, "_hold_vld"}, 32'(ovl[d]), 32'd1);
            check({tag, "_hold_sum"}, 32'(sm[d]), 32'(rs));
            check({tag, "_hold_co"}, 32'(co[d]), 32'(rc));
            check({tag, "_hold_rdy"}, 32'(irdy[d]), 32'd0);
        end
        ordy[d] = 1'b1;
        step();
        ordy[d] = 1'b0;
        check({tag, "_post_vld"}, 32'(ovl[d]), 32'd0);
        check({tag, "_post_rdy"}, 32'(irdy[d]), 32'd1);
        check({tag, "_post_sum"}, 32'(sm[d]), 32'(rs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx [2];
        int nx;
        int n;
        rst = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
        end

        // Reset state
        step();
        step();
        check("rst_rdy", 32'(irdy[0]), 32'd0);
        check("rst_vld", 32'(ovl[0]), 32'd0);
        check("rst_sum", 32'(sm[0]), 32'd0);
        check("rst_co", 32'(co[0]), 32'd0);
        check("rst_ov", 32'(ovf[0]), 32'd0);
        rst = 1'b0;
        step();
        check("rst_rel_rdy", 32'(irdy[0]), 32'd1);

        // Add, wrap, signed overflow, subtract with borrow, cross-chunk carry
        op(0, "add_basic", 16'h0001, 16'h0002, 1'b0, 1'b0, 0, 1'b0, 4, 16'h0003, 1'b0, 1'b0);
        op(0, "add_cin", 16'h0010, 16'h0020, 1'b1, 1'b0, 0, 1'b0, 4, 16'h0031, 1'b0, 1'b0);
        op(0, "add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 4,
           SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b0);
        op(0, "add_sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 4, 16'h8000, 1'b0, 1'b1);
        op(0, "sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, 4,
           SAT ? 16'h0000 : 16'hFFFE, 1'b0, 1'b0);
        op(0, "sub_sovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 4, 16'h7FFF, 1'b1, 1'b1);
        op(0, "carry_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 4, 16'h1000, 1'b0, 1'b0);

        // Backpressure in DONE plus input churn during RUN
        op(0, "bp", 16'h1234, 16'h4321, 1'b0, 1'b0, 3, 1'b1, 4, 16'h5555, 1'b0, 1'b0);

        // Back-to-back: in_valid and out_ready held high, transfers NCH+2 apart
        a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0;
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        nx = 0;
        tx[0] = 0;
        tx[1] = 0;
        for (int k = 0; k < 40 && nx < 2; k++) begin
            if (irdy[0]) begin
                tx[nx] = k;
                nx++;
            end
            step();
        end
        iv[0] = 1'b0;
        check("b2b_count", 32'(nx), 32'd2);
        check("b2b_gap", 32'(tx[1] - tx[0]), 32'd6);
        n = 0;
        while (!ovl[0] && n < 40) begin
            step();
            n++;
        end
        check("b2b_sum", 32'(sm[0]), 32'h0002);
        step();
        ordy[0] = 1'b0;
        check("b2b_idle_rdy", 32'(irdy[0]), 32'd1);

        // Reset in the middle of RUN
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        step();
        rst = 1'b1;
        iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        check("midrst_vld", 32'(ovl[0]), 32'd0);
        check("midrst_sum", 32'(sm[0]), 32'd0);
        check("midrst_rdy", 32'(irdy[0]), 32'd0);
        check("midrst_co", 32'(co[0]), 32'd0);
        rst = 1'b0;
        step();
        check("midrst_rel_rdy", 32'(irdy[0]), 32'd1);
        op(0, "after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, 4, 16'h2345, 1'b0, 1'b0);

        // CHUNK=16 configuration
        op(1, "c16_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1, 16'h1000, 1'b0, 1'b0);
        op(1, "c16_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0, 1,
           SAT ? 16'hFFFF : 16'h0000, 1'b1, 1'b0);

        // CHUNK=1 configuration
        op(2, "c1_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16, 16'h1000, 1'b0, 1'b0);
        op(2, "c1_sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 16,
           SAT ? 16'h0000 : 16'hFFFE, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chunked_seq_adder.md
Name: chunked_seq_adder

Overview:
Parametrised multi-cycle successor to the team's ripple-carry full-adder array. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, with the carry held in a register between chunks, so a wide adder costs only a CHUNK-bit carry chain. It sits between a producer and a consumer, using valid/ready handshakes on both sides, and adds a subtract mode and a signed-overflow flag.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH
NCH (localparam), WIDTH/CHUNK, number of chunk cycles per operation

Ports:
clk  input  1  rising-edge clock; single clock domain
rst  input  1  synchronous active-high reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in; used in add mode only
sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
carry_out  output  1  final carry (in sub mode, 1 = no borrow)
overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: the single clock is clk; rst is synchronous and active-high. While rst is sampled high: state=IDLE, chunk counter=0, carry register=0, sum=0, carry_out=0, overflow=0, out_valid=0, in_ready=0 during the reset cycle, then in_ready=1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Transfer occurs when in_valid&&in_ready at a rising edge.
  - On transfer: latch a; latch b, or ~b when sub=1; load carry register with cin (add) or 1 (sub); latch sub; clear the counter; go to RUN.
- RUN:
  - in_ready=0, and in_valid is ignored.
  - Each cycle, chunk k=counter computes {c, s} = A[k] + B[k] + carry_reg with CHUNK-bit arithmetic, where A[k] and B[k] are bits k*CHUNK +: CHUNK.
  - Store s into sum[k*CHUNK +: CHUNK] and c into carry_reg, then increment the counter.
  - On the last chunk (counter==NCH-1):
    - carry_out = final carry.
    - overflow = (A[WIDTH-1]==B'[WIDTH-1]) && (sum[WIDTH-1]!=A[WIDTH-1]), where B' is the latched (possibly inverted) operand.
    - Go to DONE.
- Latency: transfer at edge E0; out_valid is first high after edge E0+NCH. With CHUNK=WIDTH, out_valid is high one cycle after transfer.
- DONE:
  - out_valid=1 and in_ready=0.
  - sum, carry_out and overflow hold stable until out_ready is sampled high; then go to IDLE.
  - The result stays on sum/carry_out/overflow in IDLE until the next transfer. Consumers must qualify with out_valid.
- No overlap: a new operation is accepted no earlier than the cycle after the result handshake, so the minimum issue interval is NCH+2 cycles.
- sum is undefined-as-result during RUN (it holds partial chunks); only values qualified by out_valid are specified.
- Reset mid-operation (RUN or DONE) aborts with no out_valid pulse and returns to the reset values above.
- out_ready high while not in DONE has no effect.
- Simultaneous rst and in_valid: rst wins; no transfer.

Optional Feature:
Macro ADDER_SAT_EN.
- Defined: unsigned saturation applies to sum on completion.
  - Add mode with final carry=1: sum=all ones.
  - Sub mode with final carry=0 (borrow): sum=0.
  - carry_out and overflow still report the raw, unsaturated arithmetic.
- Undefined: sum is the raw modulo-2^WIDTH result.
- Ports, timing and latency are identical in both builds.

Test Plan:
All cases use WIDTH=16, CHUNK=4.
1. Basic add: a=0x0001, b=0x0002, cin=0, sub=0 -> out_valid high 4 cycles after transfer; sum=0x0003, carry_out=0, overflow=0.
2. Add wrap: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry_out=1, overflow=0; with ADDER_SAT_EN, sum=0xFFFF. Also a=0x7FFF, b=0x0001 -> sum=0x8000, overflow=1.
3. Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, carry_out=0; with ADDER_SAT_EN, sum=0x0000. Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, overflow=1.
4. Backpressure and protocol:
   - Hold out_ready=0 for 3 cycles in DONE -> out_valid, sum and carry_out stable throughout.
   - Change in_valid/a/b during RUN -> in_ready=0 and the result is unaffected.
   - Back-to-back operations -> second transfer no earlier than the cycle after the out handshake.
5. Reset mid-RUN: assert rst at chunk 2 -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1 afterwards; a following 0x1234+0x1111 yields 0x2345.
6. Carry propagation across chunks and config sweep:
   - a=0x0FFF, b=0x0001 -> sum=0x1000 (carry crosses 3 chunk boundaries).
   - Rerun with CHUNK=16 -> same results, out_valid 1 cycle after transfer.
   - Rerun with CHUNK=1 -> out_valid 16 cycles after transfer.
